// File: rtl/alu_op_encode.sv
// ALU control-tuple encoder: decodes {alu, inva, invb, cin, imm_pref} into an
// opcode/function pair. Legal encodings go through a 2-entry output FIFO.
// Illegal tuples are dropped and counted in a saturating counter.
module alu_op_encode #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu,
    input  logic             in_inva,
    input  logic             in_invb,
    input  logic             in_cin,
    input  logic             imm_pref,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_instr,
    output logic [1:0]       out_func,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
);

    logic [6:0]       tuple;
    logic             enc_legal;
    logic [4:0]       enc_instr;
    logic [1:0]       enc_func;

    logic [6:0]       mem_q [2];
    logic [6:0]       mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             accept;
    logic             push;
    logic             pop;

    assign tuple = {in_alu, in_inva, in_invb, in_cin};

    // Decode the request tuple; dual-form ops pick register or immediate opcode.
    always_comb begin
        logic       dual;
        logic [4:0] reg_instr;
        logic [1:0] reg_func;
        logic [4:0] imm_instr;
        dual      = 1'b0;
        reg_instr = 5'b00000;
        reg_func  = 2'b00;
        imm_instr = 5'b00000;
        enc_legal = 1'b1;
        enc_instr = 5'b00000;
        enc_func  = 2'b00;
        case (tuple)
            7'b0100_000: begin dual = 1'b1; reg_instr = 5'b11011; reg_func = 2'b00; imm_instr = 5'b01000; end
            7'b0100_101: begin dual = 1'b1; reg_instr = 5'b11011; reg_func = 2'b01; imm_instr = 5'b01001; end
            7'b0111_000: begin dual = 1'b1; reg_instr = 5'b11011; reg_func = 2'b10; imm_instr = 5'b01010; end
            7'b0101_010: begin dual = 1'b1; reg_instr = 5'b11011; reg_func = 2'b11; imm_instr = 5'b01011; end
            7'b0000_000: begin dual = 1'b1; reg_instr = 5'b11010; reg_func = 2'b00; imm_instr = 5'b10100; end
            7'b0010_000: begin dual = 1'b1; reg_instr = 5'b11010; reg_func = 2'b01; imm_instr = 5'b10101; end
            7'b0001_000: begin dual = 1'b1; reg_instr = 5'b11010; reg_func = 2'b10; imm_instr = 5'b10110; end
            7'b0011_000: begin dual = 1'b1; reg_instr = 5'b11010; reg_func = 2'b11; imm_instr = 5'b10111; end
            7'b1011_000: enc_instr = 5'b11001;
            7'b1100_011: enc_instr = 5'b11100;
            7'b1101_011: enc_instr = 5'b11101;
            7'b1110_011: enc_instr = 5'b11110;
            7'b1111_000: enc_instr = 5'b11111;
            7'b0110_000: enc_instr = 5'b01100;
            7'b0101_000: enc_instr = 5'b11000;
            default:     enc_legal = 1'b0;
        endcase
        if (dual) begin
            enc_instr = imm_pref ? imm_instr : reg_instr;
            enc_func  = imm_pref ? 2'b00 : reg_func;
        end
    end

    // Handshake: a full FIFO still accepts when its head is popped this cycle.
    always_comb begin
        out_valid = (count_q != 2'd0);
        pop       = out_valid && out_ready;
        in_ready  = (count_q != 2'd2) || pop;
        accept    = in_valid && in_ready;
        push      = accept && enc_legal;
        out_instr = mem_q[rd_ptr_q][6:2];
        out_func  = mem_q[rd_ptr_q][1:0];
        err_pulse = err_pulse_q;
        err_cnt   = err_cnt_q;
    end

    // FIFO and error-counter next state.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        err_pulse_d = accept && !enc_legal;
        err_cnt_d   = err_cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {enc_instr, enc_func};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        if (err_pulse_d && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0]    <= 7'd0;
            mem_q[1]    <= 7'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            count_q     <= 2'd0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

endmodule

// File: doc/alu_op_encode.md
ALU_OP_ENCODE -- requirements
Module: alu_op_encode

Interface
REQ-001 Parameter: CNT_W, 8, width of the illegal-request counter.
REQ-002 clk  input  1  single clock; all state rises on posedge clk.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request tuple present.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 in_alu  input  4  requested ALU control code.
REQ-007 in_inva, in_invb, in_cin  input  1 each  requested operand-invert and carry-in controls.
REQ-008 imm_pref  input  1  sampled with request; 1 = prefer immediate-form opcode when one exists.
REQ-009 out_valid  output  1  encoded instruction available.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 out_instr  output  5  encoded opcode.
REQ-012 out_func  output  2  encoded function field.
REQ-013 err_pulse  output  1  one-cycle pulse when an illegal tuple is accepted.
REQ-014 err_cnt  output  CNT_W  saturating count of illegal tuples.

Function
REQ-015 A request is accepted when in_valid && in_ready; an output is consumed when out_valid && out_ready.
REQ-016 Accepted legal tuples are encoded combinationally and written into a 2-entry FIFO; out_instr/out_func/out_valid come only from the FIFO head (registered, no combinational path from inputs to outputs).
REQ-017 Latency: legal tuple accepted in cycle N appears with out_valid=1 in cycle N+1 when the FIFO was empty.
REQ-018 in_ready = 1 when FIFO count < 2, or count == 2 and out_ready && out_valid in the same cycle; simultaneous push and pop at count 1 or 2 leaves count unchanged and preserves order.
REQ-019 Tuple notation {alu,inva,invb,cin}; register form (imm_pref=0) mapping: {0100,0,0,0}->11011/00; {0100,1,0,1}->11011/01; {0111,0,0,0}->11011/10; {0101,0,1,0}->11011/11.
REQ-020 Shift/rotate register form: {0000,000}->11010/00; {0010,000}->11010/01; {0001,000}->11010/10; {0011,000}->11010/11.
REQ-021 Immediate form (imm_pref=1) for the eight tuples of REQ-019/020: add 01000, sub 01001, xor 01010, andn 01011, 0000 10100, 0010 10101, 0001 10110, 0011 10111; func = 00.
REQ-022 Mode-independent: {1011,000}->11001; {1100,011}->11100; {1101,011}->11101; {1110,011}->11110; {1111,000}->11111; {0110,000}->01100; {0101,000}->11000; func = 00.
REQ-023 Any other tuple is illegal: accepted (in_ready rules unchanged), not written to the FIFO, err_pulse=1 the following cycle, err_cnt increments.
REQ-024 err_cnt saturates at all-ones; no wrap.
REQ-025 Illegal tuple accepted while FIFO full-with-pop: pop proceeds, no push.
REQ-026 out_instr/out_func hold stable while out_valid && !out_ready.
REQ-027 FIFO implemented as 2 entries, 1-bit read/write pointers, 2-bit count (0..2); count never exceeds 2.

Reset
REQ-028 rst_n low asynchronously clears: FIFO count and pointers to 0, out_valid=0, out_instr=00000, out_func=00, err_pulse=0, err_cnt=0; in_ready=1 after release.
REQ-029 Reset mid-operation discards all queued entries; no output is produced for requests in flight.
REQ-030 First acceptance is possible on the first posedge after rst_n deasserts.

Verification
REQ-031 Reset release, in_valid {0100,1,0,1} imm_pref=0, out_ready=1 -> next cycle out_valid=1, out_instr=11011, out_func=01.
REQ-032 Same tuple with imm_pref=1 -> out_instr=01001, out_func=00; {0011,000} imm_pref=1 -> 10111/00.
REQ-033 out_ready=0, three back-to-back legal requests -> first two queued, in_ready=0 on third; raise out_ready -> outputs drain in order, third accepted same cycle as first pop.
REQ-034 Tuple {1000,000} -> no out_valid, err_pulse for one cycle, err_cnt=1; drive 300 illegal tuples with CNT_W=8 -> err_cnt=255.
REQ-035 Assert rst_n=0 asynchronously with 2 entries queued -> out_valid=0 immediately, err_cnt=0, in_ready=1 after release.
REQ-036 Exhaustive sweep of all 128 tuples x imm_pref -> exactly the encodings of REQ-019..022 and err_pulse for all others.
